// File: rtl/load_align_extend_pkg.sv
// Shared encodings for the load align/extend unit.
package load_align_extend_pkg;
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    // Byte offset to bit offset: multiply by 8.
    localparam int BYTE_SHIFT = 3;
endpackage

// File: rtl/load_align_extend_if.sv
// Load-return stream in and extended result stream out.
interface load_align_extend_if #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 5
) ();
    localparam int OFF_WIDTH = $clog2(DATA_WIDTH / 8);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [OFF_WIDTH-1:0]  in_offset;
    logic [1:0]            in_size;
    logic                  in_signed;
    logic [TAG_WIDTH-1:0]  in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [TAG_WIDTH-1:0]  out_tag;
    logic                  out_err;

    modport slave (
        input  in_valid, in_data, in_offset, in_size, in_signed, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_err
    );

    modport master (
        output in_valid, in_data, in_offset, in_size, in_signed, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_err
    );
endinterface

// File: rtl/load_align_extend_field_extract.sv
// Combinational shift-down, mask, zero/sign extend and alignment check.
module load_field_extract
    import load_align_extend_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int OFF_WIDTH  = $clog2(DATA_WIDTH / 8)
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [OFF_WIDTH-1:0]  offset,
    input  logic [1:0]            size,
    input  logic                  sgn,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  err
);
    logic [OFF_WIDTH+BYTE_SHIFT-1:0] sh_amt;
    logic [DATA_WIDTH-1:0]           shifted;
    logic [DATA_WIDTH-1:0]           mask;
    logic [OFF_WIDTH-1:0]            align;
    logic                            sign;
    logic                            too_wide;

    assign sh_amt  = {offset, {BYTE_SHIFT{1'b0}}};
    assign shifted = data >> sh_amt;

    always_comb begin
        mask     = '1;
        align    = '0;
        sign     = 1'b0;
        too_wide = 1'b0;
        case (size_e'(size))
            SZ_B: begin
                mask = DATA_WIDTH'(64'hFF);
                sign = sgn & shifted[7];
            end
            SZ_H: begin
                mask  = DATA_WIDTH'(64'hFFFF);
                align = OFF_WIDTH'(1);
                sign  = sgn & shifted[15];
            end
            SZ_W: begin
                mask  = DATA_WIDTH'(64'hFFFF_FFFF);
                align = OFF_WIDTH'(3);
                sign  = sgn & shifted[31];
            end
            SZ_D: begin
                // Full-width on 64-bit builds; illegal on 32-bit ones.
                align    = OFF_WIDTH'(7);
                too_wide = (DATA_WIDTH < 64);
            end
            default: ;
        endcase
        err    = (|(offset & align)) | too_wide;
        result = err ? '0 : ((shifted & mask) | ({DATA_WIDTH{sign}} & ~mask));
    end
endmodule

// File: rtl/load_align_extend.sv
// Load align/extend stage: extractor at the input, main + skid result registers.
module load_align_extend
    import load_align_extend_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    load_align_extend_if.slave   bus
);
    localparam int OFF_WIDTH = $clog2(DATA_WIDTH / 8);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [TAG_WIDTH-1:0]  tag;
        logic                  err;
    } beat_t;

    beat_t nb, m_q, m_d, s_q, s_d;
    logic  m_vld_q, m_vld_d, s_vld_q, s_vld_d, rdy_q;
    logic  acc, drain;

    load_field_extract #(
        .DATA_WIDTH(DATA_WIDTH),
        .OFF_WIDTH (OFF_WIDTH)
    ) u_extract (
        .data  (bus.in_data),
        .offset(bus.in_offset),
        .size  (bus.in_size),
        .sgn   (bus.in_signed),
        .result(nb.data),
        .err   (nb.err)
    );
    assign nb.tag = bus.in_tag;

    assign acc   = bus.in_valid & rdy_q;
    assign drain = m_vld_q & bus.out_ready;

    // rdy_q is low whenever S is full, so accept and S->M promotion never coincide.
    always_comb begin
        m_d     = m_q;
        s_d     = s_q;
        m_vld_d = m_vld_q;
        s_vld_d = s_vld_q;
        if (drain) begin
            if (s_vld_q) begin
                m_d     = s_q;
                s_vld_d = 1'b0;
            end else begin
                m_vld_d = acc;
                if (acc) m_d = nb;
            end
        end else if (acc) begin
            if (!m_vld_q) begin
                m_d     = nb;
                m_vld_d = 1'b1;
            end else begin
                s_d     = nb;
                s_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_q     <= '0;
            s_q     <= '0;
            m_vld_q <= 1'b0;
            s_vld_q <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            m_q     <= m_d;
            s_q     <= s_d;
            m_vld_q <= m_vld_d;
            s_vld_q <= s_vld_d;
            rdy_q   <= !s_vld_d;
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = m_vld_q;
    assign bus.out_data  = m_q.data;
    assign bus.out_tag   = m_q.tag;
    assign bus.out_err   = m_q.err;
endmodule
